// File: rtl/fft64_pkg.sv
// Shared constants and peak FSM state type for the 64-bin FFT peak detector.
package fft64_pkg;

  localparam int unsigned FFT_N  = 64;
  localparam int unsigned BIN_W  = 6;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned PWR_W  = 48;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } peak_state_e;

endpackage

// File: rtl/fft64_mag_sq.sv
// Two-stage |x|^2 pipeline: registered squares, then registered sum; valid and tag ride along.
module fft64_mag_sq #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned PWR_W  = 48,
  parameter int unsigned TAG_W  = fft64_pkg::BIN_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [PWR_W-1:0]         out_pwr,
  output logic [TAG_W-1:0]         out_tag
);

  logic signed [PWR_W-1:0] re_ext, im_ext;
  logic [PWR_W-1:0]        sq_re_d, sq_im_d;

  logic                    v1_q;
  logic [TAG_W-1:0]        tag1_q;
  logic [PWR_W-1:0]        sq_re_q, sq_im_q;

  logic                    v2_q;
  logic [TAG_W-1:0]        tag2_q;
  logic [PWR_W-1:0]        pwr_q;

  // Sign-extend before squaring so the full-width product is exact, including (-2^23)^2.
  always_comb begin
    re_ext  = PWR_W'(in_real);
    im_ext  = PWR_W'(in_imag);
    sq_re_d = re_ext * re_ext;
    sq_im_d = im_ext * im_ext;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      tag1_q  <= '0;
      sq_re_q <= '0;
      sq_im_q <= '0;
    end else begin
      v1_q <= in_valid && !clr;
      if (in_valid) begin
        tag1_q  <= in_tag;
        sq_re_q <= sq_re_d;
        sq_im_q <= sq_im_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2_q   <= 1'b0;
      tag2_q <= '0;
      pwr_q  <= '0;
    end else begin
      v2_q <= v1_q && !clr;
      if (v1_q) begin
        tag2_q <= tag1_q;
        pwr_q  <= sq_re_q + sq_im_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_pwr   = pwr_q;
  assign out_tag   = tag2_q;

endmodule

// File: rtl/fft64_peak_detect.sv
// Per-bin power stream plus per-frame peak (bin, power) with valid/ready and sticky overwrite flag.
module fft64_peak_detect #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned PWR_W  = 48
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din_valid,
  input  logic signed [DATA_W-1:0]       din_real,
  input  logic signed [DATA_W-1:0]       din_imag,
  input  logic                           sync_clr,
  output logic                           pwr_valid,
  output logic [PWR_W-1:0]               pwr_data,
  output logic [fft64_pkg::BIN_W-1:0]    pwr_bin,
  output logic                           peak_valid,
  input  logic                           peak_ready,
  output logic [fft64_pkg::BIN_W-1:0]    peak_bin,
  output logic [PWR_W-1:0]               peak_pwr,
  output logic                           ovf
);

  import fft64_pkg::*;

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_N - 1);

  logic [BIN_W-1:0] bin_q;
  logic             in_accept;

  logic [PWR_W-1:0] max_pwr_q, cand_pwr;
  logic [BIN_W-1:0] max_bin_q, cand_bin;
  logic             frame_done;

  peak_state_e      state_q;
  logic [BIN_W-1:0] peak_bin_q;
  logic [PWR_W-1:0] peak_pwr_q;
  logic             ovf_q;

  assign in_accept = din_valid && !sync_clr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bin_q <= '0;
    end else if (sync_clr) begin
      bin_q <= '0;
    end else if (din_valid) begin
      bin_q <= bin_q + 1'b1;
    end
  end

  fft64_mag_sq #(
    .DATA_W (DATA_W),
    .PWR_W  (PWR_W),
    .TAG_W  (BIN_W)
  ) u_mag_sq (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (sync_clr),
    .in_valid  (in_accept),
    .in_real   (din_real),
    .in_imag   (din_imag),
    .in_tag    (bin_q),
    .out_valid (pwr_valid),
    .out_pwr   (pwr_data),
    .out_tag   (pwr_bin)
  );

  // Bin 0 restarts the max; later bins win only on strictly greater power.
  always_comb begin
    cand_pwr = max_pwr_q;
    cand_bin = max_bin_q;
    if (pwr_valid && ((pwr_bin == '0) || (pwr_data > max_pwr_q))) begin
      cand_pwr = pwr_data;
      cand_bin = pwr_bin;
    end
  end

  assign frame_done = pwr_valid && (pwr_bin == LastBin) && !sync_clr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      max_pwr_q <= '0;
      max_bin_q <= '0;
    end else if (sync_clr) begin
      max_pwr_q <= '0;
      max_bin_q <= '0;
    end else if (pwr_valid) begin
      max_pwr_q <= cand_pwr;
      max_bin_q <= cand_bin;
    end
  end

  // A completed frame always loads; it only counts as an overwrite if the old result was not taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StEmpty;
      peak_bin_q <= '0;
      peak_pwr_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (frame_done) begin
            peak_bin_q <= cand_bin;
            peak_pwr_q <= cand_pwr;
            state_q    <= StFull;
          end
        end
        StFull: begin
          if (frame_done) begin
            peak_bin_q <= cand_bin;
            peak_pwr_q <= cand_pwr;
            if (!peak_ready) begin
              ovf_q <= 1'b1;
            end
          end else if (peak_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign peak_valid = (state_q == StFull);
  assign peak_bin   = peak_bin_q;
  assign peak_pwr   = peak_pwr_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fft64_peak_detect.sv
// Scoreboard bench for fft64_peak_detect: directed frames, monitor compares pwr and peak streams.
module tb_fft64_peak_detect;

  localparam int DW = 24;
  localparam int PW = 48;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] din_real = '0;
  logic signed [DW-1:0] din_imag = '0;
  logic                 sync_clr = 1'b0;
  logic                 peak_ready = 1'b0;
  logic                 pwr_valid, peak_valid, ovf;
  logic [PW-1:0]        pwr_data, peak_pwr;
  logic [5:0]           pwr_bin, peak_bin;

  fft64_peak_detect #(
    .DATA_W (DW),
    .PWR_W  (PW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .sync_clr   (sync_clr),
    .pwr_valid  (pwr_valid),
    .pwr_data   (pwr_data),
    .pwr_bin    (pwr_bin),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_bin   (peak_bin),
    .peak_pwr   (peak_pwr),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned pwr;
    int              bin;
    int              cyc;
  } pwr_exp_t;

  typedef struct {
    longint unsigned pwr;
    int              bin;
  } peak_exp_t;

  pwr_exp_t  pwr_q[$];
  peak_exp_t peak_q[$];
  pwr_exp_t  pe;
  peak_exp_t ke;
  int        tests = 0;
  int        fails = 0;
  int        fr_re[64];
  int        fr_im[64];

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every presented beat / handshake must match the head of its queue.
  always @(negedge clk) begin
    if (pwr_valid) begin
      chk("pwr_expected", longint'(pwr_q.size() > 0), 1);
      if (pwr_q.size() > 0) begin
        pe = pwr_q.pop_front();
        chk("pwr_data", pwr_data, pe.pwr);
        chk("pwr_bin", pwr_bin, longint'(pe.bin));
        chk("pwr_latency", longint'(cyc), longint'(pe.cyc));
      end
    end
    if (peak_valid && peak_ready) begin
      chk("peak_expected", longint'(peak_q.size() > 0), 1);
      if (peak_q.size() > 0) begin
        ke = peak_q.pop_front();
        chk("peak_bin", peak_bin, longint'(ke.bin));
        chk("peak_pwr", peak_pwr, ke.pwr);
      end
    end
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int re, input int im, input int bin);
    pwr_exp_t e;
    din_valid = 1'b1;
    din_real  = DW'(re);
    din_imag  = DW'(im);
    e.pwr = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    e.bin = bin;
    e.cyc = cyc + 2;
    pwr_q.push_back(e);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic set_frame(input int re, input int im);
    for (int b = 0; b < 64; b++) begin
      fr_re[b] = re;
      fr_im[b] = im;
    end
  endtask

  task automatic send_frame(input bit gaps, input bit push_pk, input int exp_bin,
                            input longint unsigned exp_pwr);
    peak_exp_t k;
    for (int b = 0; b < 64; b++) begin
      if (gaps) idle(int'($urandom_range(0, 3)));
      beat(fr_re[b], fr_im[b], b);
    end
    if (push_pk) begin
      k.pwr = exp_pwr;
      k.bin = exp_bin;
      peak_q.push_back(k);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((pwr_q.size() != 0 || peak_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", longint'(pwr_q.size() + peak_q.size()), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pwr_valid"}, pwr_valid, 0);
    chk({tag, "_pwr_data"}, pwr_data, 0);
    chk({tag, "_pwr_bin"}, pwr_bin, 0);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_pwr"}, peak_pwr, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    check_zero("reset");
    rstn = 1'b1;
    peak_ready = 1'b1;
    idle(1);

    // Impulse at bin 5
    set_frame(0, 0);
    fr_re[5] = 1000;
    fr_im[5] = -1000;
    send_frame(1'b0, 1'b1, 5, 2000000);
    wait_drain();

    // Full-scale negative at bin 63
    set_frame(1, 1);
    fr_re[63] = -8388608;
    fr_im[63] = -8388608;
    send_frame(1'b0, 1'b1, 63, 64'd140737488355328);
    wait_drain();

    // Tie: lowest index wins
    set_frame(0, 0);
    fr_re[10] = 3;
    fr_im[10] = 4;
    fr_re[40] = 3;
    fr_im[40] = 4;
    send_frame(1'b0, 1'b1, 10, 25);
    wait_drain();

    // Same impulse with random gaps
    set_frame(0, 0);
    fr_re[5] = 1000;
    fr_im[5] = -1000;
    send_frame(1'b1, 1'b1, 5, 2000000);
    wait_drain();

    // 20 beats, then sync_clr with a coincident (dropped) beat, then a full frame
    for (int b = 0; b < 20; b++) beat(500, 500, b);
    idle(4);
    sync_clr  = 1'b1;
    din_valid = 1'b1;
    din_real  = 24'sd999;
    @(posedge clk);
    #1;
    sync_clr  = 1'b0;
    din_valid = 1'b0;
    set_frame(0, 0);
    fr_re[30] = -77;
    fr_im[30] = 12;
    send_frame(1'b0, 1'b1, 30, 6073);
    wait_drain();

    // Two frames unaccepted: second overwrites, ovf sets
    peak_ready = 1'b0;
    set_frame(0, 0);
    fr_re[5] = 1000;
    fr_im[5] = -1000;
    send_frame(1'b0, 1'b0, 5, 2000000);
    set_frame(0, 0);
    fr_re[10] = 3;
    fr_im[10] = 4;
    fr_re[40] = 3;
    fr_im[40] = 4;
    send_frame(1'b0, 1'b1, 10, 25);
    idle(4);
    chk("ovf_set", ovf, 1);
    chk("ovf_peak_valid", peak_valid, 1);
    chk("ovf_peak_bin", peak_bin, 10);
    peak_ready = 1'b1;
    wait_drain();

    // Reset for one cycle mid-frame
    for (int b = 0; b < 30; b++) beat(100, -3, b);
    idle(4);
    rstn = 1'b0;
    idle(1);
    check_zero("midreset");
    rstn = 1'b1;
    set_frame(2, 0);
    fr_im[17] = -9;
    send_frame(1'b0, 1'b1, 17, 85);
    wait_drain();

    // Frame completes in the same cycle as a handshake: no ovf, stays valid
    peak_ready = 1'b0;
    set_frame(0, 0);
    fr_re[5] = 1000;
    fr_im[5] = -1000;
    send_frame(1'b0, 1'b1, 5, 2000000);
    set_frame(0, 0);
    fr_re[10] = 3;
    fr_im[10] = 4;
    fr_re[40] = 3;
    fr_im[40] = 4;
    send_frame(1'b0, 1'b1, 10, 25);
    @(posedge clk);
    #1;
    peak_ready = 1'b1;
    @(posedge clk);
    #1;
    peak_ready = 1'b0;
    idle(2);
    chk("hs_ovf_clear", ovf, 0);
    chk("hs_peak_valid", peak_valid, 1);
    chk("hs_peak_bin", peak_bin, 10);
    peak_ready = 1'b1;
    wait_drain();
    idle(2);
    chk("final_peak_valid", peak_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
